serial_add_ctrl: RTL

Bit-serial adder controller. It sequences one single-bit full-adder cell over two WIDTH-bit operands, LSB first, one bit per clock, with a start/busy/done handshake. It is the team's area-minimal adder for slow-path arithmetic, where one full-adder cell plus shift registers replaces a WIDTH-bit ripple adder.

---
 rtl/serial_add_ctrl_pkg.sv | 13 +
 rtl/serial_add_ctrl_fa_cell.sv | 17 +
 rtl/serial_add_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: the state encoding
// and the default operand width.
package serial_add_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Single-bit full adder. serial_add_ctrl time-multiplexes one instance of this
// cell over every bit position of the operands.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum is the three-way parity; carry is the majority of the three inputs.
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller. Adds two WIDTH-bit operands plus a carry-in,
// LSB first, one bit per clock, using one full-adder cell. The result
// registers update only when the last bit has been produced, so callers never
// see a partial sum.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Only the upper WIDTH-1 result bits need storing: the newest bit comes
    // straight from the cell and is merged in when the sum is assembled.
    logic [WIDTH-2:0] s_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             cell_s;
    logic             cell_co;
    logic [WIDTH-1:0] s_next;

    fa_cell u_fa_cell (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (cell_s),
        .co (cell_co)
    );

    // Partial sum after this bit: the new cell output enters at the MSB.
    always_comb begin
        s_next = {cell_s, s_sr};
    end

    // Status flags are decoded straight from the state register.
    always_comb begin
        busy = (state == ST_RUN);
        done = (state == ST_DONE);
    end

    // Sequencer: accept in IDLE/DONE, shift one bit per clock in RUN, and
    // publish the result on the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            s_sr    <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            sum_out <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_sr  <= a_in;
                        b_sr  <= b_in;
                        carry <= cin;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
                    s_sr  <= s_next[WIDTH-1:1];
                    carry <= cell_co;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        sum_out <= s_next;
                        cout    <= cell_co;
                        ovf     <= carry ^ cell_co;
                        state   <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
